// File: rtl/conway_pkg.sv
// ---------------------------------------------------------------------------
// conway_pkg
// Shared types and default geometry for the grid load sequencer.
//   seq_state_t : sequencer FSM encoding (IDLE, LOAD, COMMIT, RUN)
//   GRID_ROWS   : default number of grid rows
//   GRID_COLS   : default number of cells per row
// ---------------------------------------------------------------------------
package conway_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2,
        RUN    = 2'd3
    } seq_state_t;

    localparam int GRID_ROWS = 8;
    localparam int GRID_COLS = 8;

endpackage : conway_pkg

// File: rtl/grid_load_sequencer_gen_timer.sv
// ---------------------------------------------------------------------------
// gen_timer
// Generation period timer. Counts cycles while enabled and raises a
// registered one-cycle tick on the cycle the count reaches max(period,1)-1,
// after which the count restarts from zero.
//   clk    : system clock
//   reset  : asynchronous active-low reset
//   clear  : restart the count; the first tick then lands max(period,1)
//            cycles after the clear edge
//   enable : advance the count
//   period : cycles per tick, 0 behaves as 1
//   tick   : registered one-cycle tick
// ---------------------------------------------------------------------------
module gen_timer #(
    parameter int PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] period,
    output logic                tick
);

    localparam logic [PERIOD_W-1:0] CNT_ZERO = {PERIOD_W{1'b0}};
    localparam logic [PERIOD_W-1:0] CNT_ONE  = {{(PERIOD_W-1){1'b0}}, 1'b1};

    logic [PERIOD_W-1:0] cnt_r;
    logic [PERIOD_W-1:0] cnt_s;
    logic [PERIOD_W-1:0] adv_cnt_s;
    logic [PERIOD_W-1:0] max_m1_s;
    logic                tick_r;
    logic                tick_s;

    // Compare limit: period 0 behaves as period 1.
    always_comb begin
        if (period == CNT_ZERO) begin
            max_m1_s = CNT_ZERO;
        end else begin
            max_m1_s = period - CNT_ONE;
        end
    end

    // Next count/tick. The tick is precomputed from the count the coming
    // cycle will hold, so it is a flop output. The >= compare makes a
    // shortened period fire as soon as the count is already past the limit.
    always_comb begin
        cnt_s     = cnt_r;
        tick_s    = tick_r;
        adv_cnt_s = tick_r ? CNT_ZERO : (cnt_r + CNT_ONE);
        if (clear) begin
            cnt_s  = CNT_ZERO;
            tick_s = (max_m1_s == CNT_ZERO);
        end else if (enable) begin
            cnt_s  = adv_cnt_s;
            tick_s = (adv_cnt_s >= max_m1_s);
        end else begin
            cnt_s  = cnt_r;
            tick_s = tick_r;
        end
    end

    // Counter and tick registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r  <= CNT_ZERO;
            tick_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_s;
            tick_r <= tick_s;
        end
    end

    assign tick = tick_r;

endmodule : gen_timer

// File: rtl/grid_load_sequencer.sv
// ---------------------------------------------------------------------------
// grid_load_sequencer
// Upstream control for the system grid memory. Assembles a board from
// row-wide words (valid/ready), commits it in load mode with a single write,
// then steps generations in run mode by pulsing write_enable every period.
//   clk          : system clock, rising edge
//   reset        : asynchronous active-low reset
//   start        : begin a new load (honoured in IDLE and RUN)
//   run_en       : step generations after a commit / keep running
//   period       : cycles per generation, 0 behaves as 1
//   row_data     : one grid row, first row sent is the top row
//   row_valid    : row_data valid
//   row_ready    : a row is accepted this cycle when valid
//   initial_out  : assembled board to the memory initial input
//   write_enable : memory write strobe
//   load_run     : 0 = memory loads initial_out, 1 = memory takes calculator
//   load_done    : one-cycle pulse with the commit write
//   busy         : sequencer not idle
//   gen_count    : generations stepped since the last commit
// All outputs are flops or decodes of flops; start/run_en/row_valid act at
// the clock edge, so the cycle they take effect in carries no write.
// ---------------------------------------------------------------------------
module grid_load_sequencer
    import conway_pkg::*;
#(
    parameter int ROWS      = GRID_ROWS,
    parameter int COLS      = GRID_COLS,
    parameter int DATA_SIZE = 64,
    parameter int PERIOD_W  = 16,
    parameter int GEN_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 run_en,
    input  logic [PERIOD_W-1:0]  period,
    input  logic [COLS-1:0]      row_data,
    input  logic                 row_valid,
    output logic                 row_ready,
    output logic [DATA_SIZE-1:0] initial_out,
    output logic                 write_enable,
    output logic                 load_run,
    output logic                 load_done,
    output logic                 busy,
    output logic [GEN_W-1:0]     gen_count
);

    localparam int              CNT_W    = $clog2(ROWS + 1);
    localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(ROWS - 1);
    localparam logic [CNT_W-1:0] ROW_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [GEN_W-1:0] GEN_ONE  = {{(GEN_W-1){1'b0}}, 1'b1};

    if (DATA_SIZE != ROWS * COLS) begin : g_bad_geometry
        $error("grid_load_sequencer: DATA_SIZE must equal ROWS*COLS");
    end

    seq_state_t           state_r;
    seq_state_t           next_state_s;
    logic [CNT_W-1:0]     row_cnt_r;
    logic [DATA_SIZE-1:0] board_r;
    logic [GEN_W-1:0]     gen_count_r;
    logic                 accept_s;
    logic                 row_cnt_clr_s;
    logic                 timer_clear_s;
    logic                 timer_en_s;
    logic                 tick_s;

    // Next-state logic and per-cycle strobes.
    always_comb begin
        next_state_s  = state_r;
        accept_s      = 1'b0;
        row_cnt_clr_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    next_state_s  = LOAD;
                    row_cnt_clr_s = 1'b1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            LOAD: begin
                // row_ready is high throughout LOAD, so valid alone is a handshake.
                if (row_valid) begin
                    accept_s = 1'b1;
                    if (row_cnt_r == ROW_LAST) begin
                        next_state_s = COMMIT;
                    end else begin
                        next_state_s = LOAD;
                    end
                end else begin
                    next_state_s = LOAD;
                end
            end
            COMMIT: begin
                if (run_en) begin
                    next_state_s = RUN;
                end else begin
                    next_state_s = IDLE;
                end
            end
            RUN: begin
                // start wins over run_en=0.
                if (start) begin
                    next_state_s  = LOAD;
                    row_cnt_clr_s = 1'b1;
                end else if (!run_en) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = RUN;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Row counter and board shifter: first row ends up in the top bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_cnt_r <= {CNT_W{1'b0}};
            board_r   <= {DATA_SIZE{1'b0}};
        end else begin
            if (row_cnt_clr_s) begin
                row_cnt_r <= {CNT_W{1'b0}};
            end else if (accept_s) begin
                row_cnt_r <= row_cnt_r + ROW_ONE;
            end else begin
                row_cnt_r <= row_cnt_r;
            end
            if (accept_s) begin
                board_r <= {board_r[DATA_SIZE-COLS-1:0], row_data};
            end else begin
                board_r <= board_r;
            end
        end
    end

    assign timer_clear_s = (state_r == COMMIT);
    assign timer_en_s    = (state_r == RUN);

    gen_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_gen_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clear_s),
        .enable (timer_en_s),
        .period (period),
        .tick   (tick_s)
    );

    // Generation counter: cleared by the commit, bumped by each run write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gen_count_r <= {GEN_W{1'b0}};
        end else if (state_r == COMMIT) begin
            gen_count_r <= {GEN_W{1'b0}};
        end else if ((state_r == RUN) && tick_s) begin
            gen_count_r <= gen_count_r + GEN_ONE;
        end else begin
            gen_count_r <= gen_count_r;
        end
    end

    assign row_ready    = (state_r == LOAD);
    assign load_run     = (state_r == RUN);
    assign load_done    = (state_r == COMMIT);
    assign busy         = (state_r != IDLE);
    assign write_enable = (state_r == COMMIT) || ((state_r == RUN) && tick_s);
    assign initial_out  = board_r;
    assign gen_count    = gen_count_r;

endmodule : grid_load_sequencer

// File: tb/tb_grid_load_sequencer.sv
module tb_grid_load_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic        run_en;
    logic [15:0] period;
    logic [7:0]  row_data;
    logic        row_valid;
    logic        row_ready;
    logic [63:0] initial_out;
    logic        write_enable;
    logic        load_run;
    logic        load_done;
    logic        busy;
    logic [15:0] gen_count;

    int n_cmp = 0;
    int n_err = 0;

    grid_load_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .run_en       (run_en),
        .period       (period),
        .row_data     (row_data),
        .row_valid    (row_valid),
        .row_ready    (row_ready),
        .initial_out  (initial_out),
        .write_enable (write_enable),
        .load_run     (load_run),
        .load_done    (load_done),
        .busy         (busy),
        .gen_count    (gen_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] exp_board(input logic [7:0] base);
        logic [63:0] v;
        v = 64'h0;
        for (int i = 0; i < 8; i++) begin
            v = {v[55:0], base + 8'(i)};
        end
        return v;
    endfunction

    // Present 8 rows starting at base; with gaps, an idle cycle precedes each row.
    // Returns in the cycle right after the 8th accepting edge.
    task automatic send_rows(input logic [7:0] base, input bit gaps);
        for (int i = 0; i < 8; i++) begin
            if (gaps) begin
                row_valid = 1'b0;
                row_data  = 8'hEE;
                step();
                chk("gap_ready", {63'h0, row_ready}, 64'h1);
            end
            row_valid = 1'b1;
            row_data  = base + 8'(i);
            step();
        end
        row_valid = 1'b0;
        row_data  = 8'h00;
    endtask

    task automatic check_commit(input string tag, input logic [63:0] board);
        chk({tag, "_we"}, {63'h0, write_enable}, 64'h1);
        chk({tag, "_lr"}, {63'h0, load_run}, 64'h0);
        chk({tag, "_done"}, {63'h0, load_done}, 64'h1);
        chk({tag, "_rdy"}, {63'h0, row_ready}, 64'h0);
        chk({tag, "_board"}, initial_out, board);
    endtask

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        run_en    = 1'b0;
        period    = 16'd4;
        row_data  = 8'h00;
        row_valid = 1'b0;
        step();
        step();
        chk("rst_board", initial_out, 64'h0);
        chk("rst_busy", {63'h0, busy}, 64'h0);
        chk("rst_we", {63'h0, write_enable}, 64'h0);
        chk("rst_gen", {48'h0, gen_count}, 64'h0);
        reset = 1'b1;
        step();
        chk("idle_rdy", {63'h0, row_ready}, 64'h0);

        // Reset in the middle of a load after three rows.
        start = 1'b1;
        step();
        start = 1'b0;
        chk("load_rdy", {63'h0, row_ready}, 64'h1);
        for (int i = 0; i < 3; i++) begin
            row_valid = 1'b1;
            row_data  = 8'hA0 + 8'(i);
            step();
        end
        row_valid = 1'b0;
        chk("partial_board", initial_out, 64'h0000_0000_00A0_A1A2);
        #2 reset = 1'b0;
        #1;
        chk("midrst_board", initial_out, 64'h0);
        chk("midrst_busy", {63'h0, busy}, 64'h0);
        chk("midrst_rdy", {63'h0, row_ready}, 64'h0);
        step();
        reset = 1'b1;
        step();

        // Fresh load after the abort.
        start = 1'b1;
        step();
        start = 1'b0;
        send_rows(8'h11, 1'b0);
        check_commit("fresh", exp_board(8'h11));

        // Back-to-back load of 01..08 with run_en low.
        step();
        chk("fresh_idle", {63'h0, busy}, 64'h0);
        start = 1'b1;
        step();
        start = 1'b0;
        send_rows(8'h01, 1'b0);
        check_commit("b2b", 64'h0102_0304_0506_0708);
        step();
        chk("b2b_we_off", {63'h0, write_enable}, 64'h0);
        chk("b2b_done_off", {63'h0, load_done}, 64'h0);
        chk("b2b_idle", {63'h0, busy}, 64'h0);
        chk("b2b_hold", initial_out, 64'h0102_0304_0506_0708);

        // Same load with valid toggling.
        start = 1'b1;
        step();
        start = 1'b0;
        send_rows(8'h01, 1'b1);
        check_commit("gap", 64'h0102_0304_0506_0708);
        step();
        chk("gap_idle", {63'h0, busy}, 64'h0);

        // Commit into RUN with period 4, 20 run cycles.
        run_en = 1'b1;
        period = 16'd4;
        start  = 1'b1;
        step();
        start = 1'b0;
        send_rows(8'h21, 1'b0);
        check_commit("run4", exp_board(8'h21));
        step();
        for (int c = 1; c <= 20; c++) begin
            chk($sformatf("run4_lr_%0d", c), {63'h0, load_run}, 64'h1);
            chk($sformatf("run4_we_%0d", c), {63'h0, write_enable}, {63'h0, (c % 4) == 0});
            step();
        end
        chk("run4_gen", {48'h0, gen_count}, 64'd5);

        // start with run_en low on a non-pulse cycle: back to LOAD, gen held.
        chk("sw_we", {63'h0, write_enable}, 64'h0);
        start  = 1'b1;
        run_en = 1'b0;
        step();
        start = 1'b0;
        chk("sw_rdy", {63'h0, row_ready}, 64'h1);
        chk("sw_lr", {63'h0, load_run}, 64'h0);
        chk("sw_we_load", {63'h0, write_enable}, 64'h0);
        chk("sw_gen", {48'h0, gen_count}, 64'd5);

        // Reload, then run with period 0 through the generation wrap.
        run_en = 1'b1;
        period = 16'd0;
        send_rows(8'h31, 1'b0);
        check_commit("run0", exp_board(8'h31));
        chk("run0_gen_held", {48'h0, gen_count}, 64'd5);
        step();
        chk("run0_gen_clr", {48'h0, gen_count}, 64'd0);
        chk("run0_we1", {63'h0, write_enable}, 64'h1);
        step();
        chk("run0_gen1", {48'h0, gen_count}, 64'd1);
        chk("run0_we2", {63'h0, write_enable}, 64'h1);
        for (int c = 0; c < 65534; c++) begin
            step();
        end
        chk("run0_gen_max", {48'h0, gen_count}, 64'hFFFF);
        chk("run0_we_max", {63'h0, write_enable}, 64'h1);
        step();
        chk("run0_gen_wrap", {48'h0, gen_count}, 64'h0);

        // Stop running: IDLE, load_run low, counters held.
        run_en = 1'b0;
        step();
        chk("stop_lr", {63'h0, load_run}, 64'h0);
        chk("stop_busy", {63'h0, busy}, 64'h0);
        chk("stop_we", {63'h0, write_enable}, 64'h0);
        chk("stop_gen", {48'h0, gen_count}, 64'd1);
        step();
        chk("idle_gen_hold", {48'h0, gen_count}, 64'd1);
        chk("idle_board_hold", initial_out, exp_board(8'h31));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_grid_load_sequencer

// File: doc/grid_load_sequencer.md
Name: grid_load_sequencer

Overview:
- Upstream control stage for the 64-bit system grid memory.
- Assembles an initial board from row-wide words over a valid/ready handshake, then commits it to memory in load mode.
- Then runs generations in run mode by pulsing the memory write enable every `period` cycles.
- Drives the memory's initial-data, write-enable and load/run-select inputs directly.

Parameters:
- ROWS, 8, number of grid rows.
- COLS, 8, cells per row; width of one row transfer.
- DATA_SIZE, 64, grid word width; must equal ROWS*COLS (elaboration-time assertion).
- PERIOD_W, 16, width of the generation-period input.
- GEN_W, 16, width of the generation counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset: reset low = asserted.
- start  input  1  begin a new load; sampled only in IDLE and RUN.
- run_en  input  1  allow/continue generation stepping after a commit.
- period  input  PERIOD_W  cycles per generation; 0 treated as 1.
- row_data  input  COLS  one grid row, first row sent = top row.
- row_valid  input  1  row_data valid.
- row_ready  output  1  block accepts a row this cycle.
- initial_out  output  DATA_SIZE  assembled board, to memory initial input.
- write_enable  output  1  memory write strobe.
- load_run  output  1  0 = memory takes initial_out, 1 = memory takes grid calculator output.
- load_done  output  1  one-cycle pulse, coincident with the commit write.
- busy  output  1  state != IDLE.
- gen_count  output  GEN_W  generations stepped since last commit.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset state: IDLE; all outputs 0, including initial_out, gen_count and the internal row/period counters.
- Reset mid-operation aborts any load or run immediately; a partial board is discarded.
- All outputs are registered or decoded from state only; no input-to-output combinational path.
- IDLE: row_ready=0, write_enable=0, load_run=0. start=1 -> LOAD with row_cnt cleared.
- LOAD: row_ready=1, load_run=0.
  - On each row_valid&&row_ready edge: initial_out <= {initial_out[DATA_SIZE-COLS-1:0], row_data}; row_cnt++.
  - The first row ends in bits [DATA_SIZE-1:DATA_SIZE-COLS].
  - row_valid low stalls indefinitely; no timeout.
  - start is ignored in LOAD.
  - The edge accepting row ROWS moves to COMMIT; row_ready is 0 the following cycle.
- COMMIT: exactly one cycle.
  - write_enable=1, load_run=0, load_done=1; initial_out stable.
  - gen_count cleared to 0; period counter cleared.
  - Next state is RUN if run_en=1, else IDLE. start is ignored in COMMIT.
- RUN: load_run=1, row_ready=0.
  - Period counter increments each cycle.
  - When the counter reaches max(period,1)-1: write_enable=1 that cycle, counter -> 0, gen_count++ (wraps modulo 2^GEN_W).
  - First pulse occurs max(period,1) cycles after entering RUN. period=1 or 0 gives write_enable high every cycle.
  - A period change takes effect at the next compare; if the counter is already >= the new max-1, the pulse fires on that cycle.
  - start=1 -> LOAD, with no write that cycle; start has priority over run_en=0.
  - run_en=0 (and start=0) -> IDLE; no write that cycle; load_run returns to 0 next cycle.
- Latency: the last row handshake at edge k gives the commit write during cycle k+1; memory updates at edge k+2.
- gen_count and initial_out hold their values in IDLE.

Decomposition:
- Package conway_pkg:
  - typedef enum logic [1:0] {IDLE, LOAD, COMMIT, RUN} seq_state_t.
  - Default grid constants GRID_ROWS=8, GRID_COLS=8.
- One natural sub-module: gen_timer, a PERIOD_W counter with clear/enable, period input (0->1) and a one-cycle tick output.
- The FSM, row shifter and gen_count stay in grid_load_sequencer.

Test Plan:
- Reset low mid-LOAD after 3 rows -> all outputs 0, state IDLE. A fresh start plus 8 rows then yields an initial_out containing only the new rows.
- start, 8 back-to-back rows 8'h01,8'h02..8'h08 with run_en=0:
  - initial_out = 64'h0102030405060708.
  - write_enable=1, load_run=0 and load_done=1 for exactly one cycle, then IDLE.
- Same load with row_valid toggling every other cycle -> row_ready handshakes only on valid cycles; identical initial_out; commit 1 cycle after the 8th accept.
- Commit with run_en=1, period=4 for 20 cycles -> load_run=1; write_enable pulses on RUN cycles 4, 8, 12, 16, 20; gen_count=5.
- period=0 in RUN -> write_enable high every cycle; gen_count increments each cycle and wraps from 16'hFFFF to 0.
- In RUN, assert start with run_en=0 on the same cycle -> LOAD entered, row_ready=1, no write pulse that cycle, gen_count held until the next commit clears it.
